// File: rtl/vlt_pkg.sv
// Shared types for the load-queue vulnerability scheduler: opcode codes,
// the shift-pair lookup result and the snapshot FSM state.
package vlt_pkg;

    localparam logic [8:0] LB    = 9'd0;
    localparam logic [8:0] LH    = 9'd1;
    localparam logic [8:0] LW    = 9'd2;
    localparam logic [8:0] LBU   = 9'd3;
    localparam logic [8:0] LHU   = 9'd4;
    localparam logic [8:0] LWU   = 9'd5;
    localparam logic [8:0] LD    = 9'd9;
    localparam logic [8:0] LWL   = 9'd11;
    localparam logic [8:0] LWR   = 9'd12;
    localparam logic [8:0] LDL   = 9'd13;
    localparam logic [8:0] LDR   = 9'd14;
    localparam logic [8:0] LL    = 9'd19;
    localparam logic [8:0] LLD   = 9'd20;
    localparam logic [8:0] PREF  = 9'd132;
    localparam logic [8:0] PREFX = 9'd133;

    typedef struct packed {
        logic       vld;
        logic [2:0] sh1;
        logic [2:0] sh2;
    } shift_pair_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic shift_pair_t mk_pair(input logic [2:0] s1, input logic [2:0] s2);
        shift_pair_t p;
        p.vld = 1'b1;
        p.sh1 = s1;
        p.sh2 = s2;
        return p;
    endfunction

endpackage

// File: rtl/vlt_lq_weight.sv
// Opcode/importance to shift-pair lookup, and the shift-add that turns a
// duration plus a registered shift pair into a vulnerability weight.
module vlt_lq_weight
    import vlt_pkg::*;
#(
    parameter int TS_W = 10
) (
    input  logic [8:0]      opcode_i,
    input  logic            important_i,
    output shift_pair_t     pair_o,
    input  logic [TS_W-1:0] dur_i,
    input  shift_pair_t     pair_i,
    output logic [TS_W+7:0] weight_o
);

    localparam int WGT_W = TS_W + 8;

    logic [WGT_W-1:0] dur_ext;

    always_comb begin
        pair_o = '0;
        case (opcode_i)
            LB, LH, LW, LBU, LHU, LWU, LD, LL, LLD: pair_o = mk_pair(3'd6, 3'd5);
            LWL, LWR, LDL, LDR: pair_o = important_i ? mk_pair(3'd7, 3'd5) : mk_pair(3'd6, 3'd5);
            PREF, PREFX: pair_o = mk_pair(3'd4, 3'd2);
            default: pair_o = '0;
        endcase
    end

    // Max shift is 7, so two shifted copies always fit in TS_W+8 bits.
    always_comb begin
        dur_ext  = WGT_W'(dur_i);
        weight_o = '0;
        if (pair_i.vld) begin
            weight_o = (dur_ext << pair_i.sh1) + (dur_ext << pair_i.sh2);
        end
    end

endmodule

// File: rtl/vlt_lq_sched.sv
// Round-robin retire-port scheduler feeding a 3-stage weight/accumulate pipe
// with drain-and-snapshot handshake. Define VLT_LQ_SAT_EN to saturate the accumulator.
module vlt_lq_sched
    import vlt_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int TS_W      = 10,
    parameter int ACC_W     = 48
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [NUM_PORTS-1:0]      req_v_i,
    output logic [NUM_PORTS-1:0]      req_ready_o,
    input  logic [NUM_PORTS-1:0]      important_i,
    input  logic [NUM_PORTS*9-1:0]    opcode_i,
    input  logic [NUM_PORTS*TS_W-1:0] start_ts_i,
    input  logic [NUM_PORTS*TS_W-1:0] end_ts_i,
    input  logic                      clear_i,
    input  logic                      snap_req_i,
    output logic                      snap_done_o,
    output logic [ACC_W-1:0]          snap_o,
    output logic [31:0]               snap_cnt_o,
    output logic [ACC_W-1:0]          acc_o,
    output logic                      overflow_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int WGT_W = TS_W + 8;
    localparam int SUM_W = ((ACC_W > WGT_W) ? ACC_W : WGT_W) + 1;

    state_t                 state_q, state_d;
    logic [NUM_PORTS-1:0]   pnd_q, pnd_d, gnt, accept;
    logic [PTR_W-1:0]       rr_q, rr_d, gnt_idx;
    logic                   gnt_vld;

    logic [8:0]             ent_op_q  [NUM_PORTS];
    logic [8:0]             ent_op_d  [NUM_PORTS];
    logic                   ent_imp_q [NUM_PORTS];
    logic                   ent_imp_d [NUM_PORTS];
    logic [TS_W-1:0]        ent_st_q  [NUM_PORTS];
    logic [TS_W-1:0]        ent_st_d  [NUM_PORTS];
    logic [TS_W-1:0]        ent_end_q [NUM_PORTS];
    logic [TS_W-1:0]        ent_end_d [NUM_PORTS];

    logic [TS_W-1:0]        dur_p0;
    shift_pair_t            pair_p0;
    logic [TS_W-1:0]        dur_p1_q;
    shift_pair_t            pair_p1_q;
    logic                   vld_p1_q, vld_p1_d;
    logic [WGT_W-1:0]       wgt_p1;
    logic [WGT_W-1:0]       wgt_p2_q;
    logic                   vld_p2_q, vld_p2_d;

    logic [SUM_W-1:0]       sum;
    logic                   carry;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [31:0]            cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   drained;
    logic                   snap_done_q, snap_done_d;
    logic [ACC_W-1:0]       snap_q, snap_d;
    logic [31:0]            snap_cnt_q, snap_cnt_d;

    always_comb begin
        req_ready_o = (state_q == ST_IDLE) ? (~pnd_q | gnt) : '0;
        accept      = req_v_i & req_ready_o;
    end

    always_comb begin : arb
        int               idx;
        logic [PTR_W-1:0] idx_p;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        idx_p   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            idx_p = PTR_W'(idx);
            if (!gnt_vld && pnd_q[idx_p]) begin
                gnt_vld    = 1'b1;
                gnt[idx_p] = 1'b1;
                gnt_idx    = idx_p;
            end
        end
        rr_d = rr_q;
        if (gnt_vld) begin
            rr_d = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : gnt_idx + PTR_W'(1);
        end
    end

    // A granted slot may be refilled on the same edge it empties.
    always_comb begin
        pnd_d = (pnd_q & ~gnt) | accept;
        for (int p = 0; p < NUM_PORTS; p++) begin
            ent_op_d[p]  = ent_op_q[p];
            ent_imp_d[p] = ent_imp_q[p];
            ent_st_d[p]  = ent_st_q[p];
            ent_end_d[p] = ent_end_q[p];
            if (accept[p]) begin
                ent_op_d[p]  = opcode_i[p*9 +: 9];
                ent_imp_d[p] = important_i[p];
                ent_st_d[p]  = start_ts_i[p*TS_W +: TS_W];
                ent_end_d[p] = end_ts_i[p*TS_W +: TS_W];
            end
        end
    end

    // ---- stage 0 -> p1: duration and lookup of the granted entry ----
    assign dur_p0   = ent_end_q[gnt_idx] - ent_st_q[gnt_idx];
    assign vld_p1_d = gnt_vld;

    vlt_lq_weight #(
        .TS_W (TS_W)
    ) u_weight (
        .opcode_i    (ent_op_q[gnt_idx]),
        .important_i (ent_imp_q[gnt_idx]),
        .pair_o      (pair_p0),
        .dur_i       (dur_p1_q),
        .pair_i      (pair_p1_q),
        .weight_o    (wgt_p1)
    );

    // ---- p1 -> p2: shift-add weight ----
    assign vld_p2_d = vld_p1_q;

    // ---- p2 -> accumulator ----
    always_comb begin
        sum   = SUM_W'(acc_q) + SUM_W'(wgt_p2_q);
        carry = |sum[SUM_W-1:ACC_W];
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (vld_p2_q) begin
            cnt_d = cnt_q + 32'd1;
            acc_d = sum[ACC_W-1:0];
            if (carry) begin
                ovf_d = 1'b1;
`ifdef VLT_LQ_SAT_EN
                acc_d = '1;
`else
                acc_d = sum[ACC_W-1:0];
`endif
            end
        end
    end

    // The snapshot is taken on the edge into DONE so it is valid with the pulse.
    always_comb begin
        drained     = (pnd_q == '0) && !vld_p1_q && !vld_p2_q;
        state_d     = state_q;
        snap_done_d = 1'b0;
        snap_d      = snap_q;
        snap_cnt_d  = snap_cnt_q;
        case (state_q)
            ST_IDLE:  if (snap_req_i) state_d = ST_DRAIN;
            ST_DRAIN: if (drained) begin
                state_d     = ST_DONE;
                snap_done_d = 1'b1;
                snap_d      = acc_q;
                snap_cnt_d  = cnt_q;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= ST_IDLE;
            pnd_q       <= '0;
            rr_q        <= '0;
            vld_p1_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            snap_done_q <= 1'b0;
            snap_q      <= '0;
            snap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pnd_q       <= pnd_d;
            rr_q        <= rr_d;
            vld_p1_q    <= vld_p1_d;
            vld_p2_q    <= vld_p2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            snap_done_q <= snap_done_d;
            snap_q      <= snap_d;
            snap_cnt_q  <= snap_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            ent_op_q[p]  <= ent_op_d[p];
            ent_imp_q[p] <= ent_imp_d[p];
            ent_st_q[p]  <= ent_st_d[p];
            ent_end_q[p] <= ent_end_d[p];
        end
        dur_p1_q  <= dur_p0;
        pair_p1_q <= pair_p0;
        wgt_p2_q  <= wgt_p1;
    end

    assign acc_o       = acc_q;
    assign overflow_o  = ovf_q;
    assign snap_done_o = snap_done_q;
    assign snap_o      = snap_q;
    assign snap_cnt_o  = snap_cnt_q;

endmodule

// File: doc/vlt_lq_sched.md
# vlt_lq_sched

Collects retiring load-queue entries from several retire ports and arbitrates them round-robin onto one shared vulnerability-weight datapath. For each entry it computes weight = (duration << shift1) + (duration << shift2) and adds it to a running load-queue vulnerability accumulator. It offers a drain-and-snapshot handshake so the statistics unit can read a consistent total. It sits between the LQ retire logic and the per-structure vulnerability counters.

## Interface
- NUM_PORTS, 2, number of retire ports (1..4)
- TS_W, 10, timestamp width; duration is computed modulo 2^TS_W
- ACC_W, 48, accumulator width
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- req_v_i  in  NUM_PORTS  per-port entry valid
- req_ready_o  out  NUM_PORTS  per-port ready; a transfer occurs when valid and ready are both high
- important_i  in  NUM_PORTS  per-port important flag
- opcode_i  in  NUM_PORTS×9  per-port load opcode
- start_ts_i, end_ts_i  in  NUM_PORTS×TS_W  per-port allocate and retire timestamps
- clear_i  in  1  zero the accumulator and the event count
- snap_req_i  in  1  request a drained snapshot
- snap_done_o  out  1  one-cycle pulse; snap_o and snap_cnt_o are valid from this cycle
- snap_o  out  ACC_W  snapshot of the accumulator
- snap_cnt_o  out  32  snapshot of the accumulated-entry count
- acc_o  out  ACC_W  live accumulator
- overflow_o  out  1  sticky flag, set on accumulator carry-out

## Operation
- Each port has a one-entry pending register.
  - req_ready_o[p] = !pending[p] || grant[p], and is forced to 0 outside IDLE.
- Arbiter: grants one pending port per cycle, round-robin. The pointer moves to the port after the last grant and does not move when nothing is granted.
- Lookup of (shift1, shift2, valid), applied to the granted entry:
  - opcodes 0–5, 9, 19, 20: (6, 5)
  - opcodes 11–14: (7, 5) when important, otherwise (6, 5)
  - opcodes 132, 133: (4, 2)
  - any other opcode: invalid, weight 0, but the entry is still counted
- Arithmetic:
  - duration = end_ts − start_ts, TS_W bits, so wrap-around is naturally modular.
  - weight is TS_W+8 bits.
  - weight is zero-extended to ACC_W before it is added.
- FSM:
  - IDLE: accepting. snap_req_i → DRAIN.
  - DRAIN: no new accepts; pending entries and the pipeline keep flowing. When all pending bits and all pipeline valid bits are 0 → DONE.
  - DONE: capture acc and the count into snap_o and snap_cnt_o, pulse snap_done_o, → IDLE.
- clear_i:
  - Honoured in any state.
  - Zeroes the accumulator, the count and overflow_o at the next edge.
  - If an accumulate is due on the same edge, clear wins and that weight is dropped. Entries still upstream are kept.
  - clear_i in DONE clears the live values after the snapshot is captured.
- A snap_req_i that arrives outside IDLE is ignored.
- Reset values: all pending bits, pipeline valid bits, the accumulator, the count, overflow_o, snap_o, snap_cnt_o and snap_done_o are 0. The FSM is in IDLE and the RR pointer is 0.
- Reset asserted mid-operation discards all in-flight entries immediately (asynchronous).

## Timing
- Grant in cycle N.
- Stage 1 registers the duration and the lookup result at the end of N.
- Stage 2 registers the weight at the end of N+1.
- The accumulator and the count update at the end of N+2, so acc_o reflects the entry in cycle N+3.
- Sustained throughput is one entry per cycle. A single port refilled every cycle gets a grant at most every NUM_PORTS cycles while the other ports are busy.
- snap_done_o is asserted 1 cycle after the DRAIN exit condition holds.
- The minimum snapshot latency with an empty pipeline is 2 cycles after snap_req_i (IDLE → DRAIN → DONE).

## Configuration
- VLT_LQ_SAT_EN defined: the accumulator saturates at all-ones when an add would carry out, and overflow_o is set.
- VLT_LQ_SAT_EN undefined: the accumulator wraps modulo 2^ACC_W, and overflow_o is still set, sticky, on carry-out.

## Structure
- Package vlt_pkg holds:
  - the opcode localparams (LB=0 … LLD=20, PREF=132, PREFX=133)
  - the shift-pair struct typedef
  - the FSM state enum
- Sub-module vlt_lq_weight: the combinational opcode/importance lookup plus the shift-add. It is instantiated once, after the arbiter.

## Test plan
- Port 0, LD (9), start 100, end 110 → acc_o = 960 in cycle N+3, and snap_cnt_o = 1 after a snapshot.
- Port 1, LWL (11), important, start 1020, end 4 (wrap, duration 8) → weight 1280. The same entry not important → 768.
- Both ports valid every cycle, PREF (132), duration 1 → grants alternate 0,1,0,1. After 10 entries acc_o = 200.
- snap_req_i with 2 entries pending and 2 in the pipeline → ready stays low, snap_done_o pulses once, snap_o equals the sum of all 4 weights.
- clear_i on the same edge as an accumulate of weight 96 → acc_o = 0, and the next entry starts from 0.
- With ACC_W = 12 and VLT_LQ_SAT_EN defined, accumulate past 4095 → acc_o = 4095 and overflow_o = 1. Without the macro → acc_o wraps and overflow_o = 1.
